// File: rtl/regfile_wb_arbiter.sv
// Write-port sequencer for the 32x32 register file: round-robin arbitration between
// two writeback requesters, plus a zero-fill clear sequence after reset or on demand.
module regfile_wb_arbiter #(
    parameter int NREGS          = 32,
    parameter int AW             = 5,
    parameter int DW             = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    input  logic          clr_start,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          clear_done,
    output logic          busy
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam state_e        RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
    localparam logic          RESET_BUSY  = (CLEAR_ON_RESET != 0) ? 1'b1 : 1'b0;
    localparam logic [AW-1:0] LAST_IDX    = AW'(NREGS - 1);
    localparam logic [AW-1:0] ONE_IDX     = AW'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DW-1:0] rf_wdata_q, rf_wdata_d;
    logic          clear_done_q, clear_done_d;
    logic          busy_q, busy_d;
    logic          gnt0_s, gnt1_s;

    // Combinational grant; a clr_start cycle grants nobody so no write is lost into the clear.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if ((state_q == ST_RUN) && !clr_start) begin
            case ({req1_valid, req0_valid})
                2'b01:   gnt0_s = 1'b1;
                2'b10:   gnt1_s = 1'b1;
                2'b11: begin
                    if (rr_ptr_q == 1'b0) begin
                        gnt0_s = 1'b1;
                    end else begin
                        gnt1_s = 1'b1;
                    end
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign req0_ready = gnt0_s;
    assign req1_ready = gnt1_s;

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (clr_start) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    // Next values of the registered write port, status flags, clear counter and rr pointer.
    always_comb begin
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        clear_done_d = clear_done_q;
        busy_d       = busy_q;
        cnt_d        = cnt_q;
        rr_ptr_d     = rr_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = cnt_q;
                rf_wdata_d = '0;
                if (cnt_q == LAST_IDX) begin
                    cnt_d        = '0;
                    clear_done_d = 1'b1;
                    busy_d       = 1'b0;
                end else begin
                    cnt_d        = cnt_q + ONE_IDX;
                    clear_done_d = 1'b0;
                    busy_d       = 1'b1;
                end
            end
            ST_RUN: begin
                if (clr_start) begin
                    cnt_d        = '0;
                    busy_d       = 1'b1;
                    clear_done_d = 1'b0;
                end else begin
                    busy_d       = 1'b0;
                    clear_done_d = 1'b1;
                    // x0 writes are accepted but never reach the register file.
                    if (gnt0_s) begin
                        rf_waddr_d = req0_addr;
                        rf_wdata_d = req0_data;
                        rf_we_d    = (req0_addr != '0);
                        rr_ptr_d   = 1'b1;
                    end else if (gnt1_s) begin
                        rf_waddr_d = req1_addr;
                        rf_wdata_d = req1_data;
                        rf_we_d    = (req1_addr != '0);
                        rr_ptr_d   = 1'b0;
                    end else begin
                        rf_we_d    = 1'b0;
                    end
                end
            end
            default: begin
                rf_we_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RESET_STATE;
            cnt_q        <= '0;
            rr_ptr_q     <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            clear_done_q <= 1'b0;
            busy_q       <= RESET_BUSY;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            clear_done_q <= clear_done_d;
            busy_q       <= busy_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign clear_done = clear_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: clear sequence, arbitration, x0 writes,
// clr_start restart and reset mid-clear, all against hand-computed values.
module tb_regfile_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          clr_start;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          clear_done;
    logic          busy;

    int checks_cnt;
    int fail_cnt;

    regfile_wb_arbiter #(
        .NREGS(32), .AW(AW), .DW(DW), .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .clr_start(clr_start),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .clear_done(clear_done), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs a full 32-write clear from the edge after the current point, checking each write.
    task automatic run_clear(input string name, input logic hold_req0);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("%s_rdy0_%0d", name, i), {63'd0, req0_ready}, 64'd0);
            chk($sformatf("%s_rdy1_%0d", name, i), {63'd0, req1_ready}, 64'd0);
            tick();
            chk($sformatf("%s_we_%0d", name, i), {63'd0, rf_we}, 64'd1);
            chk($sformatf("%s_addr_%0d", name, i), {59'd0, rf_waddr}, 64'(i));
            chk($sformatf("%s_data_%0d", name, i), {32'd0, rf_wdata}, 64'd0);
            chk($sformatf("%s_done_%0d", name, i), {63'd0, clear_done}, (i == 31) ? 64'd1 : 64'd0);
            chk($sformatf("%s_busy_%0d", name, i), {63'd0, busy}, (i == 31) ? 64'd0 : 64'd1);
        end
        if (hold_req0) begin
            chk($sformatf("%s_rdy0_after", name), {63'd0, req0_ready}, 64'd1);
        end else begin
            chk($sformatf("%s_rdy0_after", name), {63'd0, req0_ready}, 64'd0);
        end
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst        = 1'b1;
        clr_start  = 1'b0;
        req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
        req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;

        // Reset values
        #2;
        chk("rst_we",   {63'd0, rf_we}, 64'd0);
        chk("rst_addr", {59'd0, rf_waddr}, 64'd0);
        chk("rst_data", {32'd0, rf_wdata}, 64'd0);
        chk("rst_done", {63'd0, clear_done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd1);
        tick();
        rst = 1'b0;

        // Power-on clear
        run_clear("clr0", 1'b0);
        tick();
        chk("post_clr_we", {63'd0, rf_we}, 64'd0);

        // req0 only
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'h0000_0025;
        #1;
        chk("r0_rdy0", {63'd0, req0_ready}, 64'd1);
        chk("r0_rdy1", {63'd0, req1_ready}, 64'd0);
        tick();
        req0_valid = 1'b0;
        chk("r0_we",   {63'd0, rf_we}, 64'd1);
        chk("r0_addr", {59'd0, rf_waddr}, 64'd5);
        chk("r0_data", {32'd0, rf_wdata}, 64'h25);
        tick();
        chk("r0_we_off",  {63'd0, rf_we}, 64'd0);
        chk("r0_addr_hold", {59'd0, rf_waddr}, 64'd5);
        chk("r0_data_hold", {32'd0, rf_wdata}, 64'h25);

        // x0 write then normal req1 write (leaves rr pointer on req0)
        req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hDEAD_BEEF;
        #1;
        chk("x0_rdy1", {63'd0, req1_ready}, 64'd1);
        tick();
        chk("x0_we", {63'd0, rf_we}, 64'd0);
        req1_addr = 5'd11; req1_data = 32'h0000_0028;
        #1;
        chk("r1_rdy1", {63'd0, req1_ready}, 64'd1);
        tick();
        req1_valid = 1'b0;
        chk("r1_we",   {63'd0, rf_we}, 64'd1);
        chk("r1_addr", {59'd0, rf_waddr}, 64'd11);
        chk("r1_data", {32'd0, rf_wdata}, 64'h28);

        // Both valid: alternate 0,1,0,1
        req0_addr = 5'd9; req0_data = 32'h20;
        req1_addr = 5'd6; req1_data = 32'h40;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr_rdy0_%0d", k), {63'd0, req0_ready}, (k % 2 == 0) ? 64'd1 : 64'd0);
            chk($sformatf("rr_rdy1_%0d", k), {63'd0, req1_ready}, (k % 2 == 0) ? 64'd0 : 64'd1);
            tick();
            chk($sformatf("rr_we_%0d", k),   {63'd0, rf_we}, 64'd1);
            chk($sformatf("rr_addr_%0d", k), {59'd0, rf_waddr}, (k % 2 == 0) ? 64'd9 : 64'd6);
            chk($sformatf("rr_data_%0d", k), {32'd0, rf_wdata}, (k % 2 == 0) ? 64'h20 : 64'h40);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        chk("rr_we_off", {63'd0, rf_we}, 64'd0);

        // clr_start while req0 valid
        req0_valid = 1'b1; req0_addr = 5'd12; req0_data = 32'h30;
        clr_start  = 1'b1;
        #1;
        chk("cs_rdy0", {63'd0, req0_ready}, 64'd0);
        tick();
        clr_start = 1'b0;
        chk("cs_busy", {63'd0, busy}, 64'd1);
        chk("cs_done", {63'd0, clear_done}, 64'd0);
        chk("cs_we",   {63'd0, rf_we}, 64'd0);
        run_clear("clr1", 1'b1);
        tick();
        req0_valid = 1'b0;
        chk("cs_r0_we",   {63'd0, rf_we}, 64'd1);
        chk("cs_r0_addr", {59'd0, rf_waddr}, 64'd12);
        chk("cs_r0_data", {32'd0, rf_wdata}, 64'h30);

        // Reset at clear address 17
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 18; i++) tick();
        chk("mid_addr17", {59'd0, rf_waddr}, 64'd17);
        rst = 1'b1;
        #1;
        chk("mid_rst_we",   {63'd0, rf_we}, 64'd0);
        chk("mid_rst_addr", {59'd0, rf_waddr}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd1);
        chk("mid_rst_done", {63'd0, clear_done}, 64'd0);
        tick();
        rst = 1'b0;
        run_clear("clr2", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
